// File: rtl/gpio_mult_sequencer.sv
// Command master for the GPIO multiply/popcount peripheral: writes A1, A2, CTRL,
// waits out the compute time, reads STATUS, RESULT and ONES, returns one record per command.
module gpio_mult_sequencer #(
   parameter int          WAIT_CYCLES = 6,
   parameter logic [15:0] ADDR_A1     = 16'h037F,
   parameter logic [15:0] ADDR_A2     = 16'h0388,
   parameter logic [15:0] ADDR_CTRL   = 16'h03A0,
   parameter logic [15:0] ADDR_RES    = 16'h0390,
   parameter logic [15:0] ADDR_ONES   = 16'h0398
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_a1,
   input  logic [23:0] cmd_a2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_product,
   output logic [5:0]  res_ones,
   output logic        res_ovf,
   output logic        res_err,
   output logic [15:0] bus_addr,
   output logic        bus_wr,
   output logic        bus_rd,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   output logic        busy,
   output logic [15:0] op_count,
   output logic [3:0]  dbg_state
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_WR_A1   = 4'd1;
   localparam logic [3:0] S_WR_A2   = 4'd2;
   localparam logic [3:0] S_WR_CTRL = 4'd3;
   localparam logic [3:0] S_WAIT    = 4'd4;
   localparam logic [3:0] S_RD_STAT = 4'd5;
   localparam logic [3:0] S_RD_RES  = 4'd6;
   localparam logic [3:0] S_RD_ONES = 4'd7;
   localparam logic [3:0] S_OUT     = 4'd8;

   localparam logic [1:0] PH_SETUP  = 2'd0;
   localparam logic [1:0] PH_STROBE = 2'd1;
   localparam logic [1:0] PH_HOLD   = 2'd2;

   localparam logic [7:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

   logic [3:0]  state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [7:0]  wait_q, wait_d;
   logic [23:0] a1_q, a1_d, a2_q, a2_d;
   logic [31:0] res_product_q, res_product_d;
   logic [5:0]  res_ones_q, res_ones_d;
   logic        res_ovf_q, res_ovf_d;
   logic        res_err_q, res_err_d;
   logic [15:0] op_count_q, op_count_d;
   logic        is_wr, is_rd, last_phase;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
      return c;
   endfunction

   // Both streams transfer on a posedge where valid & ready are high; cmd_ready is
   // only offered in IDLE and res_valid only in OUT, so at most one command is in flight.
   assign cmd_ready   = (state_q == S_IDLE);
   assign res_valid   = (state_q == S_OUT);
   assign busy        = (state_q != S_IDLE);
   assign res_product = res_product_q;
   assign res_ones    = res_ones_q;
   assign res_ovf     = res_ovf_q;
   assign res_err     = res_err_q;
   assign op_count    = op_count_q;
   assign dbg_state   = state_q;

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      wait_d        = wait_q;
      a1_d          = a1_q;
      a2_d          = a2_q;
      res_product_d = res_product_q;
      res_ones_d    = res_ones_q;
      res_ovf_d     = res_ovf_q;
      res_err_d     = res_err_q;
      op_count_d    = op_count_q;
      bus_addr      = '0;
      bus_wdata     = '0;

      case (state_q)
         S_WR_A1:   begin bus_addr = ADDR_A1;   bus_wdata = {8'h00, a1_q}; end
         S_WR_A2:   begin bus_addr = ADDR_A2;   bus_wdata = {8'h00, a2_q}; end
         S_WR_CTRL: begin bus_addr = ADDR_CTRL; bus_wdata = 32'h1;         end
         S_RD_STAT: bus_addr = ADDR_CTRL;
         S_RD_RES:  bus_addr = ADDR_RES;
         S_RD_ONES: bus_addr = ADDR_ONES;
         default:   ;
      endcase

      is_wr      = state_q inside {S_WR_A1, S_WR_A2, S_WR_CTRL};
      is_rd      = state_q inside {S_RD_STAT, S_RD_RES, S_RD_ONES};
      bus_wr     = is_wr && (phase_q == PH_STROBE);
      bus_rd     = is_rd && (phase_q == PH_STROBE);
      last_phase = (is_wr || is_rd) && (phase_q == PH_HOLD);
      if (is_wr || is_rd) phase_d = last_phase ? PH_SETUP : phase_q + 2'd1;

      // Read data is captured on the edge that leaves HOLD.
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            a1_d    = cmd_a1;
            a2_d    = cmd_a2;
            state_d = S_WR_A1;
            phase_d = PH_SETUP;
         end
         S_WR_A1: if (last_phase) state_d = S_WR_A2;
         S_WR_A2: if (last_phase) state_d = S_WR_CTRL;
         S_WR_CTRL: if (last_phase) begin
            state_d = (WAIT_CYCLES == 0) ? S_RD_STAT : S_WAIT;
            wait_d  = '0;
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = S_RD_STAT;
            else                     wait_d  = wait_q + 8'd1;
         end
         S_RD_STAT: if (last_phase) begin
            res_ovf_d = ~bus_rdata[0];
            state_d   = S_RD_RES;
         end
         S_RD_RES: if (last_phase) begin
            res_product_d = bus_rdata;
            state_d       = S_RD_ONES;
         end
         S_RD_ONES: if (last_phase) begin
            res_ones_d = bus_rdata[5:0];
            res_err_d  = (bus_rdata[5:0] != popcount32(res_product_q)) || (|bus_rdata[31:6]);
            state_d    = S_OUT;
         end
         S_OUT: if (res_ready) begin
            state_d    = S_IDLE;
            op_count_d = op_count_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q       <= S_IDLE;
         phase_q       <= PH_SETUP;
         wait_q        <= '0;
         a1_q          <= '0;
         a2_q          <= '0;
         res_product_q <= '0;
         res_ones_q    <= '0;
         res_ovf_q     <= 1'b0;
         res_err_q     <= 1'b0;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         wait_q        <= wait_d;
         a1_q          <= a1_d;
         a2_q          <= a2_d;
         res_product_q <= res_product_d;
         res_ones_q    <= res_ones_d;
         res_ovf_q     <= res_ovf_d;
         res_err_q     <= res_err_d;
         op_count_q    <= op_count_d;
      end
   end

endmodule
